axi_wr_arbiter: RTL and testbench

Two-master to one-slave AXI write-path arbiter that shares a single slave write port (AW/W/B) between masters M0 and M1.
- Grants one write transaction at a time.
- Routes AW, then all W beats, then the B response, for the granted master.
- Releases the grant only after the B handshake completes.
- Sits between the masters' write interfaces and the slave-side decoder/default-slave path.

---
 rtl/axi_wr_arbiter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write arbiter: one AW -> W burst -> B transaction in flight at a time.
// Build option: define AXI_WR_ARB_FIXED_PRIO_EN for fixed M0 priority instead of round-robin.
module axi_wr_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3
) (
  input  logic                ACLK,
  input  logic                ARESETn,

  input  logic [ID_W-1:0]     M0_AWID,
  input  logic [ADDR_W-1:0]   M0_AWADDR,
  input  logic [LEN_W-1:0]    M0_AWLEN,
  input  logic [SIZE_W-1:0]   M0_AWSIZE,
  input  logic [1:0]          M0_AWBURST,
  input  logic                M0_AWVALID,
  output logic                M0_AWREADY,
  input  logic [DATA_W-1:0]   M0_WDATA,
  input  logic [DATA_W/8-1:0] M0_WSTRB,
  input  logic                M0_WLAST,
  input  logic                M0_WVALID,
  output logic                M0_WREADY,
  output logic [ID_W-1:0]     M0_BID,
  output logic [1:0]          M0_BRESP,
  output logic                M0_BVALID,
  input  logic                M0_BREADY,

  input  logic [ID_W-1:0]     M1_AWID,
  input  logic [ADDR_W-1:0]   M1_AWADDR,
  input  logic [LEN_W-1:0]    M1_AWLEN,
  input  logic [SIZE_W-1:0]   M1_AWSIZE,
  input  logic [1:0]          M1_AWBURST,
  input  logic                M1_AWVALID,
  output logic                M1_AWREADY,
  input  logic [DATA_W-1:0]   M1_WDATA,
  input  logic [DATA_W/8-1:0] M1_WSTRB,
  input  logic                M1_WLAST,
  input  logic                M1_WVALID,
  output logic                M1_WREADY,
  output logic [ID_W-1:0]     M1_BID,
  output logic [1:0]          M1_BRESP,
  output logic                M1_BVALID,
  input  logic                M1_BREADY,

  output logic [ID_W:0]       S_AWID,
  output logic [ADDR_W-1:0]   S_AWADDR,
  output logic [LEN_W-1:0]    S_AWLEN,
  output logic [SIZE_W-1:0]   S_AWSIZE,
  output logic [1:0]          S_AWBURST,
  output logic                S_AWVALID,
  input  logic                S_AWREADY,
  output logic [DATA_W-1:0]   S_WDATA,
  output logic [DATA_W/8-1:0] S_WSTRB,
  output logic                S_WLAST,
  output logic                S_WVALID,
  input  logic                S_WREADY,
  input  logic [ID_W:0]       S_BID,
  input  logic [1:0]          S_BRESP,
  input  logic                S_BVALID,
  output logic                S_BREADY,

  output logic                ERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic               grant_reg, grant_next;
  logic [LEN_W-1:0]   awlen_reg, awlen_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic               err_reg, err_next;
  logic               grant_pick;
  logic               bid_match;
  logic               b_hs;

  // Per-master views so the datapath can be indexed by the grant bit
  logic [ID_W-1:0]    m_awid    [2];
  logic [ADDR_W-1:0]  m_awaddr  [2];
  logic [LEN_W-1:0]   m_awlen   [2];
  logic [SIZE_W-1:0]  m_awsize  [2];
  logic [1:0]         m_awburst [2];
  logic [DATA_W-1:0]  m_wdata   [2];
  logic [STRB_W-1:0]  m_wstrb   [2];
  logic [1:0]         m_awvalid;
  logic [1:0]         m_wlast;
  logic [1:0]         m_wvalid;
  logic [1:0]         m_bready;

  logic [1:0]         m_awready;
  logic [1:0]         m_wready;
  logic [1:0]         m_bvalid;
  logic [ID_W-1:0]    m_bid     [2];
  logic [1:0]         m_bresp   [2];

  assign m_awid[0]    = M0_AWID;
  assign m_awid[1]    = M1_AWID;
  assign m_awaddr[0]  = M0_AWADDR;
  assign m_awaddr[1]  = M1_AWADDR;
  assign m_awlen[0]   = M0_AWLEN;
  assign m_awlen[1]   = M1_AWLEN;
  assign m_awsize[0]  = M0_AWSIZE;
  assign m_awsize[1]  = M1_AWSIZE;
  assign m_awburst[0] = M0_AWBURST;
  assign m_awburst[1] = M1_AWBURST;
  assign m_wdata[0]   = M0_WDATA;
  assign m_wdata[1]   = M1_WDATA;
  assign m_wstrb[0]   = M0_WSTRB;
  assign m_wstrb[1]   = M1_WSTRB;
  assign m_awvalid    = {M1_AWVALID, M0_AWVALID};
  assign m_wlast      = {M1_WLAST, M0_WLAST};
  assign m_wvalid     = {M1_WVALID, M0_WVALID};
  assign m_bready     = {M1_BREADY, M0_BREADY};

  // Top slave ID bit carries the owning master; responses for the other one are not ours
  assign bid_match = (S_BID[ID_W] == grant_reg);
  assign b_hs      = (state_reg == RESP) && S_BVALID && S_BREADY;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic sel;
      assign sel            = (grant_reg == 1'(gi));
      assign m_awready[gi]  = sel && (state_reg == ADDR) && S_AWREADY;
      assign m_wready[gi]   = sel && (state_reg == DATA) && S_WREADY;
      assign m_bvalid[gi]   = sel && (state_reg == RESP) && bid_match && S_BVALID;
      assign m_bid[gi]      = (sel && (state_reg == RESP)) ? S_BID[ID_W-1:0] : '0;
      assign m_bresp[gi]    = (sel && (state_reg == RESP)) ? S_BRESP : 2'b00;
    end
  endgenerate

  assign M0_AWREADY = m_awready[0];
  assign M1_AWREADY = m_awready[1];
  assign M0_WREADY  = m_wready[0];
  assign M1_WREADY  = m_wready[1];
  assign M0_BVALID  = m_bvalid[0];
  assign M1_BVALID  = m_bvalid[1];
  assign M0_BID     = m_bid[0];
  assign M1_BID     = m_bid[1];
  assign M0_BRESP   = m_bresp[0];
  assign M1_BRESP   = m_bresp[1];

  // Slave-side mux: each channel only carries the granted master in its own phase
  always_comb begin
    S_AWID    = '0;
    S_AWADDR  = '0;
    S_AWLEN   = '0;
    S_AWSIZE  = '0;
    S_AWBURST = '0;
    S_AWVALID = 1'b0;
    S_WDATA   = '0;
    S_WSTRB   = '0;
    S_WLAST   = 1'b0;
    S_WVALID  = 1'b0;
    S_BREADY  = 1'b0;
    case (state_reg)
      ADDR: begin
        S_AWID    = {grant_reg, m_awid[grant_reg]};
        S_AWADDR  = m_awaddr[grant_reg];
        S_AWLEN   = m_awlen[grant_reg];
        S_AWSIZE  = m_awsize[grant_reg];
        S_AWBURST = m_awburst[grant_reg];
        S_AWVALID = m_awvalid[grant_reg];
      end
      DATA: begin
        S_WDATA   = m_wdata[grant_reg];
        S_WSTRB   = m_wstrb[grant_reg];
        S_WLAST   = m_wlast[grant_reg];
        S_WVALID  = m_wvalid[grant_reg];
      end
      RESP: begin
        S_BREADY  = bid_match && m_bready[grant_reg];
      end
      default: ;
    endcase
  end

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
  assign grant_pick = ~m_awvalid[0];
`else
  logic last_grant_reg;

  always_comb begin
    if (m_awvalid == 2'b11) begin
      grant_pick = ~last_grant_reg;
    end else begin
      grant_pick = ~m_awvalid[0];
    end
  end

  // Starts at M1 so that M0 wins the first tie after reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      last_grant_reg <= 1'b1;
    end else if (b_hs) begin
      last_grant_reg <= grant_reg;
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    awlen_next    = awlen_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|m_awvalid) begin
          grant_next = grant_pick;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (S_AWVALID && S_AWREADY) begin
          awlen_next    = m_awlen[grant_reg];
          beat_cnt_next = '0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (S_WVALID && S_WREADY) begin
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          // Count is the zero-based index of this beat; the final one must equal AWLEN
          if (S_WLAST) begin
            err_next   = (beat_cnt_reg != {1'b0, awlen_reg});
            state_next = RESP;
          end else begin
            err_next   = (beat_cnt_reg == {1'b0, awlen_reg});
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      awlen_reg    <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      awlen_reg    <= awlen_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign ERR = err_reg;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: master and slave sides driven from one initial block,
// expected AW/W/B traffic queued at stimulus time and compared when the DUT presents it.
module tb_axi_wr_arbiter;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [ID_W-1:0]     awid    [2];
  logic [ADDR_W-1:0]   awaddr  [2];
  logic [LEN_W-1:0]    awlen   [2];
  logic [SIZE_W-1:0]   awsize  [2];
  logic [1:0]          awburst [2];
  logic [DATA_W-1:0]   wdata   [2];
  logic [DATA_W/8-1:0] wstrb   [2];
  logic [1:0]          awvalid, wvalid, wlast, bready;

  wire                 m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
  wire [ID_W-1:0]      m0_bid, m1_bid;
  wire [1:0]           m0_bresp, m1_bresp;

  wire [ID_W:0]        s_awid;
  wire [ADDR_W-1:0]    s_awaddr;
  wire [LEN_W-1:0]     s_awlen;
  wire [SIZE_W-1:0]    s_awsize;
  wire [1:0]           s_awburst;
  wire                 s_awvalid;
  wire [DATA_W-1:0]    s_wdata;
  wire [DATA_W/8-1:0]  s_wstrb;
  wire                 s_wlast, s_wvalid, s_bready, err;
  logic                s_awready, s_wready, s_bvalid;
  logic [ID_W:0]       s_bid;
  logic [1:0]          s_bresp;

  axi_wr_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_AWID(awid[0]), .M0_AWADDR(awaddr[0]), .M0_AWLEN(awlen[0]), .M0_AWSIZE(awsize[0]),
    .M0_AWBURST(awburst[0]), .M0_AWVALID(awvalid[0]), .M0_AWREADY(m0_awready),
    .M0_WDATA(wdata[0]), .M0_WSTRB(wstrb[0]), .M0_WLAST(wlast[0]), .M0_WVALID(wvalid[0]),
    .M0_WREADY(m0_wready), .M0_BID(m0_bid), .M0_BRESP(m0_bresp), .M0_BVALID(m0_bvalid),
    .M0_BREADY(bready[0]),
    .M1_AWID(awid[1]), .M1_AWADDR(awaddr[1]), .M1_AWLEN(awlen[1]), .M1_AWSIZE(awsize[1]),
    .M1_AWBURST(awburst[1]), .M1_AWVALID(awvalid[1]), .M1_AWREADY(m1_awready),
    .M1_WDATA(wdata[1]), .M1_WSTRB(wstrb[1]), .M1_WLAST(wlast[1]), .M1_WVALID(wvalid[1]),
    .M1_WREADY(m1_wready), .M1_BID(m1_bid), .M1_BRESP(m1_bresp), .M1_BVALID(m1_bvalid),
    .M1_BREADY(bready[1]),
    .S_AWID(s_awid), .S_AWADDR(s_awaddr), .S_AWLEN(s_awlen), .S_AWSIZE(s_awsize),
    .S_AWBURST(s_awburst), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
    .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WLAST(s_wlast), .S_WVALID(s_wvalid),
    .S_WREADY(s_wready), .S_BID(s_bid), .S_BRESP(s_bresp), .S_BVALID(s_bvalid),
    .S_BREADY(s_bready), .ERR(err)
  );

  typedef struct packed {
    logic [ID_W:0]      id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
  } aw_t;
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               last;
  } w_t;
  typedef struct packed {
    logic [ID_W-1:0]    bid;
    logic [1:0]         bresp;
  } b_t;

  aw_t aw_q[$];
  w_t  w_q[$];
  b_t  b_q[$];
  int  checks = 0;
  int  failures = 0;
  int  second, other;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_awready(input int m);
    return (m == 1) ? m1_awready : m0_awready;
  endfunction
  function automatic logic get_wready(input int m);
    return (m == 1) ? m1_wready : m0_wready;
  endfunction
  function automatic logic get_bvalid(input int m);
    return (m == 1) ? m1_bvalid : m0_bvalid;
  endfunction
  function automatic logic [ID_W-1:0] get_bid(input int m);
    return (m == 1) ? m1_bid : m0_bid;
  endfunction
  function automatic logic [1:0] get_bresp(input int m);
    return (m == 1) ? m1_bresp : m0_bresp;
  endfunction

  task automatic req_aw(input int m, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [LEN_W-1:0] len);
    awid[m] = id; awaddr[m] = addr; awlen[m] = len;
    awsize[m] = 3'd2; awburst[m] = 2'b01; awvalid[m] = 1'b1;
  endtask

  task automatic exp_aw(input int m);
    aw_t e;
    e.id = {1'(m), awid[m]}; e.addr = awaddr[m]; e.len = awlen[m];
    aw_q.push_back(e);
  endtask

  task automatic aw_phase(input int m);
    aw_t e;
    int  n = 0;
    #1;
    while (!s_awvalid && n < 20) begin
      chk("wready_before_grant", get_wready(m), 0);
      @(negedge ACLK); #1; n++;
    end
    chk("aw_wait", s_awvalid, 1);
    if (s_awvalid && aw_q.size() > 0) begin
      e = aw_q.pop_front();
      s_awready = 1'b1; #1;
      chk("s_awid", s_awid, e.id);
      chk("s_awaddr", s_awaddr, e.addr);
      chk("s_awlen", s_awlen, e.len);
      chk("s_awsize", s_awsize, 3'd2);
      chk("s_awburst", s_awburst, 2'b01);
      chk("m_awready", get_awready(m), 1);
      chk("other_awready", get_awready(1 - m), 0);
      chk("wready_in_addr", get_wready(m), 0);
      @(negedge ACLK);
      s_awready = 1'b0; awvalid[m] = 1'b0;
    end
  endtask

  task automatic w_phase(input int m, input int nbeats, input logic [DATA_W-1:0] base,
                         input bit toggle, input int exp_err);
    w_t e;
    int sent = 0, cyc = 0, errs = 0;
    for (int i = 0; i < nbeats; i++) begin
      e.data = base + DATA_W'(i); e.last = (i == nbeats - 1);
      w_q.push_back(e);
    end
    while (sent < nbeats && cyc < 100) begin
      wvalid[m] = 1'b1; wdata[m] = base + DATA_W'(sent); wstrb[m] = '1;
      wlast[m] = (sent == nbeats - 1);
      s_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (err) errs++;
      chk("other_wready", get_wready(1 - m), 0);
      if (s_wvalid && s_wready) begin
        e = w_q.pop_front();
        chk("s_wdata", s_wdata, e.data);
        chk("s_wlast", s_wlast, e.last);
        chk("s_wstrb", s_wstrb, 4'hF);
        chk("m_wready", get_wready(m), 1);
        sent++;
      end else if (s_wvalid) begin
        chk("m_wready_stall", get_wready(m), 0);
      end
      @(negedge ACLK); cyc++;
    end
    wvalid[m] = 1'b0; wlast[m] = 1'b0; s_wready = 1'b0;
    #1;
    if (err) errs++;
    chk("w_beats", sent, nbeats);
    chk("err_pulses", errs, exp_err);
  endtask

  task automatic b_phase(input int m, input logic [ID_W-1:0] id, input logic [1:0] resp);
    b_t e;
    e.bid = id; e.bresp = resp;
    b_q.push_back(e);
    bready[m] = 1'b1; s_bvalid = 1'b1; s_bid = {~1'(m), id}; s_bresp = resp; #1;
    chk("bvalid_foreign_id", get_bvalid(m), 0);
    chk("s_bready_foreign_id", s_bready, 0);
    @(negedge ACLK);
    s_bid = {1'(m), id}; #1;
    e = b_q.pop_front();
    chk("m_bvalid", get_bvalid(m), 1);
    chk("other_bvalid", get_bvalid(1 - m), 0);
    chk("m_bid", get_bid(m), e.bid);
    chk("m_bresp", get_bresp(m), e.bresp);
    chk("s_bready", s_bready, 1);
    @(negedge ACLK);
    s_bvalid = 1'b0; bready[m] = 1'b0; s_bid = '0; s_bresp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
    for (int i = 0; i < 2; i++) begin
      awid[i] = '0; awaddr[i] = '0; awlen[i] = '0; awsize[i] = '0; awburst[i] = '0;
      wdata[i] = '0; wstrb[i] = '0;
    end
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00;

    // Reset state
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_s_awvalid", s_awvalid, 0);
    chk("rst_s_awid", s_awid, 0);
    chk("rst_s_wvalid", s_wvalid, 0);
    chk("rst_s_bready", s_bready, 0);
    chk("rst_m0_bid", m0_bid, 0);
    chk("rst_err", err, 0);
    @(negedge ACLK); ARESETn = 1'b1;
    @(negedge ACLK);

    // 1: M0 single beat
    req_aw(0, 4'd3, 32'h0000_1000, 4'd0);
    exp_aw(0);
    @(negedge ACLK); #1;
    chk("aw_latency", s_awvalid, 1);
    chk("t1_s_awid", s_awid, 5'h03);
    aw_phase(0);
    w_phase(0, 1, 32'hDEAD_BEEF, 1'b0, 0);
    b_phase(0, 4'd3, 2'b00);
    $display("txn1 M0 single write done checks=%0d", checks);

    // 3: M1 burst with stalling slave
    req_aw(1, 4'd5, 32'h0000_2000, 4'd3);
    exp_aw(1);
    @(negedge ACLK);
    aw_phase(1);
    w_phase(1, 4, 32'h0000_00A0, 1'b1, 0);
    b_phase(1, 4'd5, 2'b01);
    $display("txn3 M1 burst done checks=%0d", checks);

    // 2: simultaneous requests twice in a row
    req_aw(0, 4'd1, 32'h0000_3000, 4'd0);
    req_aw(1, 4'd2, 32'h0000_3100, 4'd0);
    exp_aw(0);
    @(negedge ACLK);
    aw_phase(0);
    w_phase(0, 1, 32'h0000_0011, 1'b0, 0);
    b_phase(0, 4'd1, 2'b00);
    $display("txn2a tie winner M0 done checks=%0d", checks);
    req_aw(0, 4'd6, 32'h0000_3200, 4'd0);
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
    second = 0;
`else
    second = 1;
`endif
    other = 1 - second;
    exp_aw(second);
    @(negedge ACLK);
    aw_phase(second);
    w_phase(second, 1, 32'h0000_0022, 1'b0, 0);
    b_phase(second, awid[second], 2'b00);
    $display("txn2b tie winner M%0d done checks=%0d", second, checks);
    exp_aw(other);
    @(negedge ACLK);
    aw_phase(other);
    w_phase(other, 1, 32'h0000_0033, 1'b0, 0);
    b_phase(other, awid[other], 2'b00);
    $display("txn2c remaining M%0d done checks=%0d", other, checks);

    // 4: early WLAST
    req_aw(0, 4'd7, 32'h0000_4000, 4'd3);
    exp_aw(0);
    @(negedge ACLK);
    aw_phase(0);
    w_phase(0, 2, 32'h0000_0055, 1'b0, 1);
    b_phase(0, 4'd7, 2'b10);
    $display("txn4 M0 short burst done checks=%0d", checks);

    // 5: M1 presents W before its grant
    req_aw(0, 4'd8, 32'h0000_5000, 4'd1);
    exp_aw(0);
    @(negedge ACLK);
    aw_phase(0);
    req_aw(1, 4'd9, 32'h0000_5100, 4'd1);
    exp_aw(1);
    wvalid[1] = 1'b1; wdata[1] = 32'h0000_0077; wstrb[1] = '1; wlast[1] = 1'b0;
    w_phase(0, 2, 32'h0000_0066, 1'b0, 0);
    b_phase(0, 4'd8, 2'b00);
    aw_phase(1);
    w_phase(1, 2, 32'h0000_0077, 1'b0, 0);
    b_phase(1, 4'd9, 2'b00);
    $display("txn5 early W from M1 done checks=%0d", checks);

    // 6: reset during DATA
    req_aw(0, 4'd2, 32'h0000_6000, 4'd3);
    exp_aw(0);
    @(negedge ACLK);
    aw_phase(0);
    wvalid[0] = 1'b1; wdata[0] = 32'h0000_0099; wstrb[0] = '1; s_wready = 1'b1;
    #2;
    ARESETn = 1'b0;
    #1;
    chk("rst6_s_wvalid", s_wvalid, 0);
    chk("rst6_m0_wready", m0_wready, 0);
    chk("rst6_s_wdata", s_wdata, 0);
    chk("rst6_s_awvalid", s_awvalid, 0);
    chk("rst6_s_bready", s_bready, 0);
    chk("rst6_m0_bvalid", m0_bvalid, 0);
    wvalid[0] = 1'b0; s_wready = 1'b0;
    @(negedge ACLK); ARESETn = 1'b1;
    @(negedge ACLK);
    req_aw(1, 4'd4, 32'h0000_7000, 4'd0);
    exp_aw(1);
    @(negedge ACLK); #1;
    chk("rst6_regrant_latency", s_awvalid, 1);
    aw_phase(1);
    w_phase(1, 1, 32'h0000_00C3, 1'b0, 0);
    b_phase(1, 4'd4, 2'b00);
    $display("txn6 reset in DATA then M1 done checks=%0d", checks);

    chk("aw_queue_empty", aw_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
